hdlc_rx_frame_ctrl: RTL and testbench
=====================================

Name: hdlc_rx_frame_ctrl

Overview:
Control FSM that sequences the HDLC Rx datapath. It consumes the flag, abort and byte-valid indications from the Rx deserializer and the FCS checker. It generates the frame-level controls and status: Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_Overflow, Rx_FrameError, Rx_Ready and the frame size. It sits between the Rx bit-level logic and the Rx buffer / CPU status register.

Parameters:
MAX_BYTES, 128, Rx buffer depth in bytes; the write after this many bytes overflows.
MIN_BYTES, 4, minimum received bytes (FCS included) for a valid frame.
FCS_BYTES, 2, FCS bytes stripped from Rx_FrameSize when Rx_FCSen=1.

Ports:
Clk  in  1  system clock.
Rst  in  1  reset; Rst is synchronous, active-high.
Rx_FlagDetect  in  1  1-cycle pulse, flag (0x7E) received.
Rx_AbortDetect  in  1  1-cycle pulse, abort pattern received.
Rx_NewByte  in  1  1-cycle pulse, deserializer holds a complete data byte.
Rx_FCSerr  in  1  FCS checker result, valid in the cycle Rx_FlagDetect closes a frame.
Rx_FCSen  in  1  FCS checking enabled (CPU config).
Rx_Drop  in  1  1-cycle pulse from CPU, discard current/held frame.
Rx_RdDone  in  1  1-cycle pulse, CPU has read the held frame.
Rx_ValidFrame  out  1  frame in progress.
Rx_WrBuff  out  1  1-cycle pulse, write byte to buffer at Rx_WrAddr.
Rx_WrAddr  out  $clog2(MAX_BYTES)  buffer write address.
Rx_EoF  out  1  1-cycle pulse, frame ended (closing flag or abort).
Rx_AbortSignal  out  1  sticky, frame aborted.
Rx_Overflow  out  1  sticky, more than MAX_BYTES bytes received.
Rx_FrameError  out  1  sticky, FCS error or frame too short.
Rx_Ready  out  1  a good frame is held in the buffer.
Rx_FrameSize  out  8  payload bytes of the held frame.

Behaviour:
- All outputs are registered; each response appears on the cycle after the triggering input.
- Reset: state=IDLE, byte count=0, every output 0.
- States: IDLE, FRAME, HOLD.
- IDLE:
  - Rx_FlagDetect -> FRAME; set Rx_ValidFrame=1; clear count, Rx_AbortSignal, Rx_Overflow, Rx_FrameError.
  - All other inputs are ignored.
- FRAME, Rx_NewByte:
  - If count<MAX_BYTES: pulse Rx_WrBuff with Rx_WrAddr=count, then count++.
  - Otherwise: set Rx_Overflow; no write; count saturates at MAX_BYTES.
- FRAME, Rx_FlagDetect with count=0: shared/idle flags; stay in FRAME, no EoF.
- FRAME, Rx_FlagDetect with count>0: closing flag.
  - Rx_ValidFrame=0 and Rx_EoF=1 for one cycle.
  - Rx_FrameError=1 if (Rx_FCSen && Rx_FCSerr) or count<MIN_BYTES.
  - If Rx_FrameError or Rx_Overflow: Rx_Ready=0 -> IDLE.
  - Else: Rx_Ready=1, Rx_FrameSize=count-(Rx_FCSen?FCS_BYTES:0) -> HOLD.
- FRAME, Rx_AbortDetect:
  - Rx_AbortSignal=1, Rx_EoF pulse, Rx_ValidFrame=0, Rx_Ready=0 -> IDLE.
- FRAME, Rx_Drop:
  - Rx_ValidFrame=0 -> IDLE; no Rx_EoF; status bits unchanged.
- HOLD:
  - Rx_RdDone or Rx_Drop -> Rx_Ready=0, Rx_FrameSize=0 -> IDLE.
  - Rx_FlagDetect, Rx_NewByte and Rx_AbortDetect are ignored; frames arriving in HOLD are lost.
- Priority in one cycle: Rx_AbortDetect > Rx_Drop > Rx_FlagDetect > Rx_NewByte. The losing event is discarded; in particular, no buffer write occurs in an abort cycle.
- Status bits are sticky until the next IDLE->FRAME transition or Rst.
- Rst asserted mid-frame or in HOLD returns to reset values on the next edge, with no Rx_EoF.

Decomposition:
- Package hdlc_pkg holds rx_state_t (IDLE, FRAME, HOLD) and the default constants MAX_BYTES, MIN_BYTES and FCS_BYTES.
- One sub-module, hdlc_rx_byte_counter: saturating counter with clear, increment and a full flag at MAX_BYTES. It drives Rx_WrAddr.

Test Plan:
- Good frame: flag, 6 bytes, flag, Rx_FCSen=1, Rx_FCSerr=0 -> 6 Rx_WrBuff pulses at addr 0..5; Rx_EoF 1 cycle; Rx_Ready=1; Rx_FrameSize=4. Then Rx_RdDone -> Rx_Ready=0 next cycle.
- FCS error: same frame with Rx_FCSerr=1 -> Rx_EoF, Rx_FrameError=1, Rx_Ready=0, state IDLE.
- Abort: flag, 3 bytes, Rx_AbortDetect coincident with Rx_NewByte -> no 4th write; next cycle Rx_AbortSignal=1, Rx_EoF=1, Rx_ValidFrame=0.
- Overflow: flag, 130 bytes, flag -> exactly 128 writes; Rx_Overflow=1 from byte 129; Rx_Ready=0 at Rx_EoF.
- Back-to-back flags then 2-byte frame: 3 flags, 2 bytes, flag -> a single Rx_EoF; Rx_FrameError=1 (short frame).
- HOLD behaviour: good frame held, a second full frame arrives -> no writes, Rx_FrameSize unchanged. Then Rx_Drop -> Rx_Ready=0. Rst asserted mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared types and default sizing for the HDLC receive control path.
package hdlc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        HOLD  = 2'd2
    } rx_state_t;

    localparam int MAX_BYTES = 128;
    localparam int MIN_BYTES = 4;
    localparam int FCS_BYTES = 2;

endpackage

// File: rtl/hdlc_rx_byte_counter.sv
// Saturating byte counter for the Rx buffer; registers the write address of each counted byte.
module hdlc_rx_byte_counter #(
    parameter int MAX_BYTES = 128,
    localparam int CW = $clog2(MAX_BYTES + 1),
    localparam int AW = $clog2(MAX_BYTES)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Clr,
    input  logic          Inc,
    output logic [CW-1:0] Count,
    output logic [AW-1:0] WrAddr,
    output logic          Full
);

    assign Full = (Count == CW'(MAX_BYTES));

    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            Count  <= '0;
            WrAddr <= '0;
        end else if (Inc && !Full) begin
            // The address presented with the write strobe is the pre-increment count.
            WrAddr <= Count[AW-1:0];
            Count  <= Count + 1'b1;
        end
    end

endmodule

// File: rtl/hdlc_rx_frame_ctrl.sv
// Rx frame sequencer: turns flag/abort/byte events into buffer writes and frame status.
//
//   state | meaning
//   IDLE  | waiting for an opening flag; everything else ignored
//   FRAME | receiving bytes into the buffer
//   HOLD  | good frame held for the CPU; line activity discarded
module hdlc_rx_frame_ctrl import hdlc_pkg::*; #(
    parameter int MAX_BYTES = hdlc_pkg::MAX_BYTES,
    parameter int MIN_BYTES = hdlc_pkg::MIN_BYTES,
    parameter int FCS_BYTES = hdlc_pkg::FCS_BYTES,
    localparam int CW = $clog2(MAX_BYTES + 1),
    localparam int AW = $clog2(MAX_BYTES)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Rx_FlagDetect,
    input  logic          Rx_AbortDetect,
    input  logic          Rx_NewByte,
    input  logic          Rx_FCSerr,
    input  logic          Rx_FCSen,
    input  logic          Rx_Drop,
    input  logic          Rx_RdDone,
    output logic          Rx_ValidFrame,
    output logic          Rx_WrBuff,
    output logic [AW-1:0] Rx_WrAddr,
    output logic          Rx_EoF,
    output logic          Rx_AbortSignal,
    output logic          Rx_Overflow,
    output logic          Rx_FrameError,
    output logic          Rx_Ready,
    output logic [7:0]    Rx_FrameSize
);

    rx_state_t     state, stateNext;
    logic          validNext, wrBuffNext, eofNext, abortNext;
    logic          overflowNext, errorNext, readyNext;
    logic [7:0]    sizeNext;
    logic          cntClr, cntInc, cntFull;
    logic [CW-1:0] count;
    logic          closeErr;
    logic [7:0]    fcsAdj;

    hdlc_rx_byte_counter #(.MAX_BYTES(MAX_BYTES)) uCounter (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clr    (cntClr),
        .Inc    (cntInc),
        .Count  (count),
        .WrAddr (Rx_WrAddr),
        .Full   (cntFull)
    );

    assign closeErr = (Rx_FCSen && Rx_FCSerr) || (count < CW'(MIN_BYTES));
    assign fcsAdj   = Rx_FCSen ? 8'(FCS_BYTES) : 8'd0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= IDLE;
            Rx_ValidFrame  <= 1'b0;
            Rx_WrBuff      <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            Rx_Overflow    <= 1'b0;
            Rx_FrameError  <= 1'b0;
            Rx_Ready       <= 1'b0;
            Rx_FrameSize   <= 8'd0;
        end else begin
            state          <= stateNext;
            Rx_ValidFrame  <= validNext;
            Rx_WrBuff      <= wrBuffNext;
            Rx_EoF         <= eofNext;
            Rx_AbortSignal <= abortNext;
            Rx_Overflow    <= overflowNext;
            Rx_FrameError  <= errorNext;
            Rx_Ready       <= readyNext;
            Rx_FrameSize   <= sizeNext;
        end
    end

    always_comb begin
        stateNext    = state;
        validNext    = Rx_ValidFrame;
        wrBuffNext   = 1'b0;
        eofNext      = 1'b0;
        abortNext    = Rx_AbortSignal;
        overflowNext = Rx_Overflow;
        errorNext    = Rx_FrameError;
        readyNext    = Rx_Ready;
        sizeNext     = Rx_FrameSize;
        cntClr       = 1'b0;
        cntInc       = 1'b0;

        case (state)
            IDLE: begin
                if (Rx_FlagDetect) begin
                    stateNext    = FRAME;
                    validNext    = 1'b1;
                    cntClr       = 1'b1;
                    abortNext    = 1'b0;
                    overflowNext = 1'b0;
                    errorNext    = 1'b0;
                end
            end

            FRAME: begin
                // Event priority: abort, drop, flag, byte; the loser is dropped.
                if (Rx_AbortDetect) begin
                    stateNext = IDLE;
                    abortNext = 1'b1;
                    eofNext   = 1'b1;
                    validNext = 1'b0;
                    readyNext = 1'b0;
                end else if (Rx_Drop) begin
                    stateNext = IDLE;
                    validNext = 1'b0;
                end else if (Rx_FlagDetect) begin
                    // A flag with no bytes yet is a shared/idle flag, not a frame end.
                    if (count != '0) begin
                        validNext = 1'b0;
                        eofNext   = 1'b1;
                        errorNext = Rx_FrameError || closeErr;
                        if (closeErr || Rx_FrameError || Rx_Overflow) begin
                            stateNext = IDLE;
                            readyNext = 1'b0;
                        end else begin
                            stateNext = HOLD;
                            readyNext = 1'b1;
                            sizeNext  = 8'(count) - fcsAdj;
                        end
                    end
                end else if (Rx_NewByte) begin
                    if (!cntFull) begin
                        wrBuffNext = 1'b1;
                        cntInc     = 1'b1;
                    end else begin
                        overflowNext = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (Rx_RdDone || Rx_Drop) begin
                    stateNext = IDLE;
                    readyNext = 1'b0;
                    sizeNext  = 8'd0;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Self-checking bench for hdlc_rx_frame_ctrl; buffer writes are scored against an address queue.
module tb_hdlc_rx_frame_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx_FlagDetect = 1'b0;
    logic       Rx_AbortDetect = 1'b0;
    logic       Rx_NewByte = 1'b0;
    logic       Rx_FCSerr = 1'b0;
    logic       Rx_FCSen = 1'b0;
    logic       Rx_Drop = 1'b0;
    logic       Rx_RdDone = 1'b0;
    logic       Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_AbortSignal;
    logic       Rx_Overflow, Rx_FrameError, Rx_Ready;
    logic [6:0] Rx_WrAddr;
    logic [7:0] Rx_FrameSize;

    int checkCount = 0;
    int errCount   = 0;
    int expAddrQ[$];
    int nextAddr   = 0;

    always #5 Clk = ~Clk;

    hdlc_rx_frame_ctrl dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_FCSerr      (Rx_FCSerr),
        .Rx_FCSen       (Rx_FCSen),
        .Rx_Drop        (Rx_Drop),
        .Rx_RdDone      (Rx_RdDone),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_WrBuff      (Rx_WrBuff),
        .Rx_WrAddr      (Rx_WrAddr),
        .Rx_EoF         (Rx_EoF),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_Overflow    (Rx_Overflow),
        .Rx_FrameError  (Rx_FrameError),
        .Rx_Ready       (Rx_Ready),
        .Rx_FrameSize   (Rx_FrameSize)
    );

    task automatic checkVal(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every buffer write must match the oldest expected address.
    always @(negedge Clk) begin
        if (Rx_WrBuff) begin
            if (expAddrQ.size() == 0) begin
                checkVal("wr_unexpected", 1, 0);
            end else begin
                checkVal("wr_addr", int'(Rx_WrAddr), expAddrQ.pop_front());
            end
        end
    end

    // Inputs are driven after a falling edge; on return the registered response is visible.
    task automatic step(input logic flag, input logic abort, input logic newByte,
                        input logic drop, input logic rdDone);
        Rx_FlagDetect  = flag;
        Rx_AbortDetect = abort;
        Rx_NewByte     = newByte;
        Rx_Drop        = drop;
        Rx_RdDone      = rdDone;
        @(negedge Clk);
        Rx_FlagDetect  = 1'b0;
        Rx_AbortDetect = 1'b0;
        Rx_NewByte     = 1'b0;
        Rx_Drop        = 1'b0;
        Rx_RdDone      = 1'b0;
    endtask

    task automatic openFrame();
        nextAddr = 0;
        step(1, 0, 0, 0, 0);
    endtask

    task automatic sendByte(input bit expectWrite);
        if (expectWrite) begin
            expAddrQ.push_back(nextAddr);
            nextAddr++;
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic sendBytes(input int n, input bit expectWrite);
        for (int i = 0; i < n; i++) sendByte(expectWrite);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_valid"}, Rx_ValidFrame, 0);
        checkVal({tag, "_wr"}, Rx_WrBuff, 0);
        checkVal({tag, "_addr"}, int'(Rx_WrAddr), 0);
        checkVal({tag, "_eof"}, Rx_EoF, 0);
        checkVal({tag, "_abort"}, Rx_AbortSignal, 0);
        checkVal({tag, "_ovf"}, Rx_Overflow, 0);
        checkVal({tag, "_err"}, Rx_FrameError, 0);
        checkVal({tag, "_ready"}, Rx_Ready, 0);
        checkVal({tag, "_size"}, int'(Rx_FrameSize), 0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        checkAllZero("reset");

        // Events in IDLE other than a flag are ignored.
        step(0, 1, 1, 0, 0);
        checkVal("idle_abort_ignored", Rx_AbortSignal, 0);
        checkVal("idle_valid", Rx_ValidFrame, 0);

        // Good frame with FCS stripping.
        Rx_FCSen = 1'b1;
        openFrame();
        checkVal("good_valid", Rx_ValidFrame, 1);
        sendBytes(6, 1);
        step(1, 0, 0, 0, 0);
        checkVal("good_eof", Rx_EoF, 1);
        checkVal("good_valid_low", Rx_ValidFrame, 0);
        checkVal("good_ready", Rx_Ready, 1);
        checkVal("good_size", int'(Rx_FrameSize), 4);
        checkVal("good_err", Rx_FrameError, 0);
        step(0, 0, 0, 0, 0);
        checkVal("good_eof_pulse", Rx_EoF, 0);
        step(0, 0, 0, 0, 1);
        checkVal("rddone_ready", Rx_Ready, 0);
        checkVal("rddone_size", int'(Rx_FrameSize), 0);

        // FCS error.
        openFrame();
        sendBytes(6, 1);
        Rx_FCSerr = 1'b1;
        step(1, 0, 0, 0, 0);
        Rx_FCSerr = 1'b0;
        checkVal("fcs_eof", Rx_EoF, 1);
        checkVal("fcs_err", Rx_FrameError, 1);
        checkVal("fcs_ready", Rx_Ready, 0);
        sendByte(0);
        checkVal("fcs_idle_valid", Rx_ValidFrame, 0);
        checkVal("fcs_err_sticky", Rx_FrameError, 1);

        // Abort coinciding with a byte: no write for that byte.
        openFrame();
        checkVal("abort_err_cleared", Rx_FrameError, 0);
        sendBytes(3, 1);
        step(0, 1, 1, 0, 0);
        checkVal("abort_sig", Rx_AbortSignal, 1);
        checkVal("abort_eof", Rx_EoF, 1);
        checkVal("abort_valid", Rx_ValidFrame, 0);
        checkVal("abort_wr", Rx_WrBuff, 0);

        // Overflow: 128 writes, then overflow from byte 129.
        openFrame();
        checkVal("ovf_abort_cleared", Rx_AbortSignal, 0);
        sendBytes(128, 1);
        checkVal("ovf_before", Rx_Overflow, 0);
        checkVal("ovf_last_addr", int'(Rx_WrAddr), 127);
        sendByte(0);
        checkVal("ovf_set", Rx_Overflow, 1);
        checkVal("ovf_nowr", Rx_WrBuff, 0);
        sendByte(0);
        step(1, 0, 0, 0, 0);
        checkVal("ovf_eof", Rx_EoF, 1);
        checkVal("ovf_ready", Rx_Ready, 0);
        checkVal("ovf_sticky", Rx_Overflow, 1);

        // Shared flags then a short frame.
        openFrame();
        checkVal("b2b_ovf_cleared", Rx_Overflow, 0);
        step(1, 0, 0, 0, 0);
        checkVal("b2b_flag2_eof", Rx_EoF, 0);
        step(1, 0, 0, 0, 0);
        checkVal("b2b_flag3_eof", Rx_EoF, 0);
        checkVal("b2b_valid", Rx_ValidFrame, 1);
        sendBytes(2, 1);
        step(1, 0, 0, 0, 0);
        checkVal("short_eof", Rx_EoF, 1);
        checkVal("short_err", Rx_FrameError, 1);
        checkVal("short_ready", Rx_Ready, 0);

        // HOLD ignores line activity.
        Rx_FCSen = 1'b0;
        openFrame();
        sendBytes(5, 1);
        step(1, 0, 0, 0, 0);
        checkVal("hold_ready", Rx_Ready, 1);
        checkVal("hold_size", int'(Rx_FrameSize), 5);
        step(1, 0, 0, 0, 0);
        sendBytes(4, 0);
        step(1, 0, 0, 0, 0);
        checkVal("hold_flag_eof", Rx_EoF, 0);
        step(0, 1, 0, 0, 0);
        checkVal("hold_abort_ignored", Rx_AbortSignal, 0);
        checkVal("hold_size_kept", int'(Rx_FrameSize), 5);
        checkVal("hold_ready_kept", Rx_Ready, 1);
        step(0, 0, 0, 1, 0);
        checkVal("hold_drop_ready", Rx_Ready, 0);

        // Drop beats a coincident flag mid-frame: no EoF.
        openFrame();
        sendBytes(5, 1);
        step(1, 0, 0, 1, 0);
        checkVal("drop_eof", Rx_EoF, 0);
        checkVal("drop_valid", Rx_ValidFrame, 0);
        checkVal("drop_ready", Rx_Ready, 0);

        // Reset mid-frame.
        openFrame();
        sendBytes(3, 1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checkAllZero("rst_mid");

        repeat (2) @(negedge Clk);
        checkVal("wr_queue_empty", expAddrQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
